// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one external combinational full adder,
// LSB first, with a start/busy/done handshake and carry/overflow reporting.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             carry, carry_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  // Holds the WIDTH-1 bits already produced; the last bit comes straight from fa_s.
  logic [WIDTH-2:0] sum_sh, sum_sh_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             overflow_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] sum_cat_c;

  assign fa_a      = a_sh[0];
  assign fa_b      = b_sh[0];
  assign fa_cin    = carry;
  assign sum_cat_c = {fa_s, sum_sh};

  // Next-state and datapath update.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    carry_nxt    = carry;
    a_sh_nxt     = a_sh;
    b_sh_nxt     = b_sh;
    sum_sh_nxt   = sum_sh;
    sum_nxt      = sum;
    cout_nxt     = cout;
    overflow_nxt = overflow;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sh_nxt   = a;
          b_sh_nxt   = sub ? ~b : b;
          carry_nxt  = sub ? 1'b1 : cin;
          count_nxt  = '0;
          sum_sh_nxt = '0;
          busy_nxt   = 1'b1;
          state_nxt  = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        sum_sh_nxt = sum_cat_c[WIDTH-1:1];
        carry_nxt  = fa_cout;
        a_sh_nxt   = {1'b0, a_sh[WIDTH-1:1]};
        b_sh_nxt   = {1'b0, b_sh[WIDTH-1:1]};
        count_nxt  = count + CNT_W'(1);
        busy_nxt   = 1'b1;
        // MSB slice: carry in vs carry out gives signed overflow.
        if (count == LAST_BIT) begin
          sum_nxt      = sum_cat_c;
          cout_nxt     = fa_cout;
          overflow_nxt = fa_cin ^ fa_cout;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = DONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset dominates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      carry    <= carry_nxt;
      a_sh     <= a_sh_nxt;
      b_sh     <= b_sh_nxt;
      sum_sh   <= sum_sh_nxt;
      sum      <= sum_nxt;
      cout     <= cout_nxt;
      overflow <= overflow_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed WIDTH=8 vectors plus an
// exhaustive WIDTH=4 sweep, each instance wired to a behavioural full adder.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, sub, cin;
  logic [7:0] a, b;
  logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic       busy, done, cout, overflow;
  logic [7:0] sum;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       fa_a4, fa_b4, fa_cin4, fa_s4, fa_cout4;
  logic       busy4, done4, cout4, overflow4;
  logic [3:0] sum4;

  assign fa_s     = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_s4    = fa_a4 ^ fa_b4 ^ fa_cin4;
  assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_s(fa_s4), .fa_cout(fa_cout4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(overflow4)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp8_t;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp4_t;

  exp8_t q8[$];
  exp4_t q4[$];
  logic  car4 [4];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int step4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WIDTH=8 instance: result, latency and busy length on every done.
  always @(negedge clk) begin
    exp8_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          check("sum8", 32'(sum), 32'(e.sum));
          check("cout8", 32'(cout), 32'(e.cout));
          check("ovf8", 32'(overflow), 32'(e.ovf));
          check("done_cycle8", 32'(cyc), 32'(e.cyc));
          check("busy_len8", 32'(busy_cnt), 32'(W));
        end
        busy_cnt = 0;
      end
    end
  end

  // Monitor for the WIDTH=4 instance: ripple carry per step and final result.
  always @(negedge clk) begin
    exp4_t e;
    if (reset) begin
      step4 = 0;
    end else begin
      if (busy4) begin
        if (step4 < 4) check("fa_cin4", 32'(fa_cin4), 32'(car4[step4]));
        else check("busy4_overrun", 32'(step4), 32'd3);
        step4++;
      end
      if (done4) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          check("sum4", 32'(sum4), 32'(e.sum));
          check("cout4", 32'(cout4), 32'(e.cout));
          check("ovf4", 32'(overflow4), 32'(e.ovf));
        end
        step4 = 0;
      end
    end
  end

  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo, input bit expect_it);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    if (expect_it) q8.push_back('{es, ec, eo, cyc + W});
    start = 1'b0;
  endtask

  task automatic wait_done8;
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("timeout_done8", 32'd0, 32'd1);
  endtask

  task automatic wait_done4;
    int n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done4) check("timeout_done4", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d1, d2;
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_fa_a", 32'(fa_a), 32'd0);
    check("rst_fa_b", 32'(fa_b), 32'd0);
    check("rst_fa_cin", 32'(fa_cin), 32'd0);

    issue8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1); wait_done8();
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); wait_done8();
    issue8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1); wait_done8();
    issue8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1); wait_done8();
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1); wait_done8();

    // start during RUN must be ignored; then restart in the DONE cycle
    issue8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done8();
    d1 = cyc;
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    wait_done8();
    d2 = cyc;
    check("b2b_gap", 32'(d2 - d1), 32'(W + 1));

    // reset in the 4th RUN cycle aborts without a done pulse
    issue8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    issue8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1); wait_done8();

    // exhaustive WIDTH=4 sweep against signed/unsigned integer arithmetic
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            int bb, c0, r, sa, sb, sv;
            bb = (s != 0) ? ((~y) & 15) : y;
            c0 = (s != 0) ? 1 : c;
            r  = x + bb + c0;
            sa = (x >= 8) ? x - 16 : x;
            sb = (y >= 8) ? y - 16 : y;
            sv = (s != 0) ? sa - sb : sa + sb + c;
            for (int i = 0; i < 4; i++) begin
              int m;
              m = (1 << i) - 1;
              car4[i] = 1'(((x & m) + (bb & m) + c0) >> i);
            end
            a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); sub4 = 1'(s); start4 = 1'b1;
            @(posedge clk); #1;
            q4.push_back('{4'(r), 1'((r >> 4) & 1), (sv > 7 || sv < -8)});
            start4 = 1'b0;
            wait_done4();
          end
        end
      end
    end

    repeat (4) begin @(posedge clk); #1; end
    check("pending8", 32'(q8.size()), 32'd0);
    check("pending4", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
